// File: rtl/cpu7_csr_wrpipe.sv
// CSR write pipeline: carries csrwr/csrxchg writes through E and M and commits from M.
// Optional CSR_WRPIPE_CNT_EN adds a 32-bit csr_commit_cnt output counting commits.
module cpu7_csr_wrpipe #(
  parameter int CSR_ADDR_W = 14,
  parameter int CSR_DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_wen_d,
  input  logic [CSR_ADDR_W-1:0] csr_waddr_d,
  input  logic [CSR_DATA_W-1:0] csr_wdata_d,
  input  logic [CSR_DATA_W-1:0] csr_wmask_d,
  input  logic [CSR_DATA_W-1:0] csr_rdata_d,
  input  logic                  pipe_stall,
  input  logic                  kill_e,
  input  logic                  kill_m,
  output logic                  csr_wen_e,
  output logic [CSR_ADDR_W-1:0] csr_waddr_e,
  output logic [CSR_DATA_W-1:0] csr_wdata_e,
  output logic                  csr_wen_m,
  output logic [CSR_ADDR_W-1:0] csr_waddr_m,
  output logic [CSR_DATA_W-1:0] csr_wdata_m,
  output logic                  csrrf_wen,
  output logic [CSR_ADDR_W-1:0] csrrf_waddr,
  output logic [CSR_DATA_W-1:0] csrrf_wdata,
`ifdef CSR_WRPIPE_CNT_EN
  output logic [31:0]           csr_commit_cnt,
`endif
  output logic                  csr_busy
);

  logic                  v_e, v_m;
  logic [CSR_ADDR_W-1:0] addr_e, addr_m;
  logic [CSR_DATA_W-1:0] data_e, data_m;
  logic [CSR_DATA_W-1:0] merged;

  // csrxchg merge is resolved once here so every forwarded value is final
  assign merged = (csr_rdata_d & ~csr_wmask_d) | (csr_wdata_d & csr_wmask_d);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_e    <= 1'b0;
      v_m    <= 1'b0;
      addr_e <= '0;
      addr_m <= '0;
      data_e <= '0;
      data_m <= '0;
    end else if (kill_m) begin
      v_e <= 1'b0;
      v_m <= 1'b0;
    end else if (kill_e) begin
      v_e <= 1'b0;
      if (!pipe_stall) begin
        v_m    <= v_e;
        addr_m <= addr_e;
        data_m <= data_e;
      end
    end else if (!pipe_stall) begin
      v_m    <= v_e;
      addr_m <= addr_e;
      data_m <= data_e;
      v_e    <= csr_wen_d;
      addr_e <= csr_waddr_d;
      data_e <= merged;
    end
  end

  assign csr_wen_e   = v_e;
  assign csr_waddr_e = addr_e;
  assign csr_wdata_e = data_e;
  assign csr_wen_m   = v_m;
  assign csr_waddr_m = addr_m;
  assign csr_wdata_m = data_m;

  // M only commits on the edge it advances, so a held entry never re-commits
  assign csrrf_wen   = v_m & ~pipe_stall & ~kill_m;
  assign csrrf_waddr = addr_m;
  assign csrrf_wdata = data_m;
  assign csr_busy    = v_e | v_m;

`ifdef CSR_WRPIPE_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      csr_commit_cnt <= '0;
    else if (csrrf_wen)
      csr_commit_cnt <= csr_commit_cnt + 32'd1;
  end
`endif

endmodule
